// File: rtl/abs_diff_window_acc_if.sv
// Handshake bundle between the subtractor stage, the window accumulator and its consumer.
interface abs_diff_window_acc_if #(
  parameter int unsigned N      = 32,
  parameter int unsigned WINDOW = 9
);
  localparam int unsigned SUM_W = N + $clog2(WINDOW);
  localparam int unsigned CNT_W = $clog2(WINDOW + 1);

  // Sample stream from the subtractor
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_diff;
  logic             in_neg;

  // One result per window
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [CNT_W-1:0] out_neg_count;
  logic [CNT_W-1:0] out_zero_count;
  logic             out_edge;

  // Producer of samples and consumer of results
  modport master (
    output in_valid, in_diff, in_neg, out_ready,
    input  in_ready, out_valid, out_sum, out_neg_count, out_zero_count, out_edge
  );

  // The accumulator itself
  modport slave (
    input  in_valid, in_diff, in_neg, out_ready,
    output in_ready, out_valid, out_sum, out_neg_count, out_zero_count, out_edge
  );
endinterface

// File: rtl/abs_diff_window_acc.sv
// Sum of absolute differences over a WINDOW-sample window, with negative/zero
// counts and a threshold edge decision, one registered result per window.
module abs_diff_window_acc #(
  parameter  int unsigned N      = 32,
  parameter  int unsigned WINDOW = 9,
  localparam int unsigned SUM_W  = N + $clog2(WINDOW),
  localparam int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [SUM_W-1:0]     threshold,
  output logic                 busy,
  abs_diff_window_acc_if.slave bus
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  state_t           state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] neg_q, neg_d;
  logic [CNT_W-1:0] zero_q, zero_d;
  logic [CNT_W-1:0] idx_q, idx_d;

  logic             accept;
  logic             res_load;
  logic [SUM_W-1:0] sum_fin;
  logic [CNT_W-1:0] neg_fin;
  logic [CNT_W-1:0] zero_fin;

  // Handshake outputs follow the state register; in_ready is held low during reset
  assign bus.in_ready  = (state_q == ACCUM) && !rst;
  assign bus.out_valid = (state_q == DONE);

  // Next-state and accumulator update; flush wins over an offered sample
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    idx_d    = idx_q;
    res_load = 1'b0;
    accept   = bus.in_valid && bus.in_ready && !flush;
    sum_fin  = acc_q + SUM_W'(bus.in_diff);
    neg_fin  = neg_q + CNT_W'(bus.in_neg);
    zero_fin = zero_q + CNT_W'(bus.in_diff == '0);

    unique case (state_q)
      ACCUM: begin
        if (flush) begin
          acc_d  = '0;
          neg_d  = '0;
          zero_d = '0;
          idx_d  = '0;
        end else if (accept) begin
          if (idx_q == LAST_IDX) begin
            res_load = 1'b1;
            acc_d    = '0;
            neg_d    = '0;
            zero_d   = '0;
            idx_d    = '0;
            state_d  = DONE;
          end else begin
            acc_d  = sum_fin;
            neg_d  = neg_fin;
            zero_d = zero_fin;
            idx_d  = idx_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and running accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      neg_q   <= '0;
      zero_q  <= '0;
      idx_q   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      idx_q   <= idx_d;
      busy    <= (state_d == DONE) || (idx_d != '0);
    end
  end

  // Result registers, loaded only when the window's last sample is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_sum        <= '0;
      bus.out_neg_count  <= '0;
      bus.out_zero_count <= '0;
      bus.out_edge       <= 1'b0;
    end else if (res_load) begin
      bus.out_sum        <= sum_fin;
      bus.out_neg_count  <= neg_fin;
      bus.out_zero_count <= zero_fin;
      bus.out_edge       <= (sum_fin >= threshold);
    end
  end

endmodule
